// File: rtl/lsu_ram_pkg.sv
// Shared types and helpers for the LSU-to-RAMCtrl adapter.
// Size encodings, FSM states, lane mask and load extension.
package lsu_ram_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Bit mask with 0xFF in each byte lane the access covers.
  function automatic logic [63:0] lane_mask(logic [1:0] size,
                                            logic [2:0] off);
    logic [7:0]  be;
    logic [63:0] m;
    case (size)
      SZ_B:    be = 8'h01;
      SZ_H:    be = 8'h03;
      SZ_W:    be = 8'h0F;
      default: be = 8'hFF;
    endcase
    be = be << off;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Sign or zero extend the low bytes of an LSB-justified value.
  function automatic logic [63:0] extend(logic [63:0] d,
                                         logic [1:0]  size,
                                         logic        uns);
    case (size)
      SZ_B: return uns ? {56'b0, d[7:0]}
                       : {{56{d[7]}}, d[7:0]};
      SZ_H: return uns ? {48'b0, d[15:0]}
                       : {{48{d[15]}}, d[15:0]};
      SZ_W: return uns ? {32'b0, d[31:0]}
                       : {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ram_adapter_if.sv
// LSU-side request/response channel of the RAM adapter.
// master = LSU, slave = adapter.
interface lsu_ram_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata,
    output req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata,
    input  req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment between LSU data and 8-byte RAM words.
// Store: shift data and build mask. Load: shift down and extend.
module lsu_lane_align
  import lsu_ram_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] st_data,
  input  logic [63:0] ld_raw,
  output logic [63:0] st_data_sh,
  output logic [63:0] st_mask,
  output logic [63:0] ld_data
);

  logic [5:0] shamt;

  // Lane shift amount in bits and the data paths that use it.
  always_comb begin
    shamt      = {offset, 3'b000};
    st_data_sh = st_data << shamt;
    st_mask    = lane_mask(size, offset);
    ld_data    = extend(ld_raw >> shamt, size, uns);
  end

endmodule

// File: rtl/lsu_ram_adapter.sv
// Single-outstanding LSU request adapter in front of RAMCtrl.
// IDLE -> ISSUE -> CAPTURE -> RESP, or IDLE -> RESP on error.
module lsu_ram_adapter
  import lsu_ram_pkg::*;
#(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0800_0000
) (
  input  logic         clock,
  input  logic         reset,
  lsu_ram_adapter_if.slave lsu,
  output logic [63:0]  ram_raddr,
  output logic         ram_rflag,
  input  logic [63:0]  ram_rdata,
  output logic [63:0]  ram_waddr,
  output logic [63:0]  ram_wdata,
  output logic [63:0]  ram_wmask,
  output logic         ram_wen
);

  localparam logic [64:0] LAST = {1'b0, MEM_BASE + MEM_SIZE - 64'd1};

  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        bad;
  logic [3:0]  nb;
  logic [2:0]  amask;
  logic [64:0] last;
  logic        issue;
  logic [63:0] st_sh, st_mask, ld_data;

  lsu_lane_align u_align (
    .offset     (addr_q[2:0]),
    .size       (size_q),
    .uns        (uns_q),
    .st_data    (wdata_q),
    .ld_raw     (ram_rdata),
    .st_data_sh (st_sh),
    .st_mask    (st_mask),
    .ld_data    (ld_data)
  );

  // Handshake, RAM port drive and request legality check.
  always_comb begin
    lsu.req_ready  = (state_q == S_IDLE) && !reset;
    lsu.resp_valid = (state_q == S_RESP);
    lsu.resp_rdata = rdata_q;
    lsu.resp_err   = err_q;
    accept = lsu.req_valid && lsu.req_ready;
    issue  = (state_q == S_ISSUE) && !reset;
    ram_raddr = {addr_q[63:3], 3'b000};
    ram_waddr = {addr_q[63:3], 3'b000};
    ram_rflag = issue && !wen_q;
    ram_wen   = issue && wen_q;
    ram_wmask = issue ? st_mask : 64'd0;
    ram_wdata = issue ? st_sh : 64'd0;
    nb    = size_bytes(lsu.req_size);
    amask = 3'(nb - 4'd1);
    last  = {1'b0, lsu.req_addr} + {61'd0, nb} - 65'd1;
    bad   = |(lsu.req_addr[2:0] & amask)
         || (lsu.req_addr < MEM_BASE)
         || (last > LAST);
  end

  // Next-state and request/response register updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = lsu.req_addr;
          wen_d   = lsu.req_wen;
          wdata_d = lsu.req_wdata;
          size_d  = lsu.req_size;
          uns_d   = lsu.req_unsigned;
          if (bad) begin
            state_d = S_RESP;
            rdata_d = 64'd0;
            err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        rdata_d = wen_q ? 64'd0 : ld_data;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (lsu.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_ram_adapter.sv
// Self-checking bench for lsu_ram_adapter.
// Behavioural RAMCtrl model plus expected-response queue.
module tb_lsu_ram_adapter;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] ram_raddr, ram_waddr;
  logic [63:0] ram_wdata, ram_wmask;
  logic [63:0] ram_rdata;
  logic        ram_rflag, ram_wen;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];
  logic [63:0] mem [logic [63:0]];

  logic        saw_wen, saw_rflag;
  logic [63:0] obs_wmask, obs_wdata;

  lsu_ram_adapter_if bus ();

  lsu_ram_adapter dut (
    .clock     (clock),
    .reset     (reset),
    .lsu       (bus.slave),
    .ram_raddr (ram_raddr),
    .ram_rflag (ram_rflag),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .ram_wen   (ram_wen)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] rd(logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  // RAMCtrl model: masked write, registered read.
  always @(posedge clock) begin
    if (ram_wen)
      mem[ram_waddr] = (rd(ram_waddr) & ~ram_wmask)
                     | (ram_wdata & ram_wmask);
    if (ram_rflag) ram_rdata <= rd(ram_raddr);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request, called and returning at a negedge.
  task automatic xact(input logic [63:0] addr,
                      input logic        wen,
                      input logic [63:0] wdata,
                      input logic [1:0]  size,
                      input logic        uns,
                      input logic [63:0] exp_rd,
                      input logic        exp_err,
                      input int          exp_lat,
                      input int          hold);
    exp_t e;
    int lat;
    bus.req_valid    = 1'b1;
    bus.req_addr     = addr;
    bus.req_wen      = wen;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sb_q.push_back(e);
    saw_wen   = 1'b0;
    saw_rflag = 1'b0;
    obs_wmask = '0;
    obs_wdata = '0;
    @(posedge clock);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clock);
      lat++;
      if (ram_wen) begin
        saw_wen   = 1'b1;
        obs_wmask = ram_wmask;
        obs_wdata = ram_wdata;
      end
      if (ram_rflag) saw_rflag = 1'b1;
      if (bus.resp_valid || lat > 20) break;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (!bus.resp_valid) begin
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q[0];
    for (int i = 0; i < hold; i++) begin
      chk("bp_rdata", bus.resp_rdata, e.rdata);
      chk("bp_err", 64'(bus.resp_err), 64'(e.err));
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_valid", 64'(bus.resp_valid), 64'd1);
      @(negedge clock);
    end
    bus.resp_ready = 1'b1;
    e = sb_q.pop_front();
    chk("resp_rdata", bus.resp_rdata, e.rdata);
    chk("resp_err", 64'(bus.resp_err), 64'(e.err));
    @(posedge clock);
    #1 bus.resp_ready = 1'b0;
    @(negedge clock);
    chk("idle_after", 64'(bus.req_ready), 64'd1);
  endtask

  localparam logic [63:0] D0 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] OLD = 64'h0123_4567_89AB_CDEF;

  initial begin
    reset = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wen      = 1'b0;
    bus.req_wdata    = '0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    chk("rst_err", 64'(bus.resp_err), 64'd0);
    chk("rst_raddr", ram_raddr, 64'd0);
    chk("rst_wen", 64'(ram_wen), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 64'(bus.req_ready), 64'd1);

    xact(64'h8000_0010, 1, D0, 2'd3, 0, 64'd0, 0, 3, 0);
    chk("sd_wmask", obs_wmask, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sd_wdata", obs_wdata, D0);
    chk("sd_wen", 64'(saw_wen), 64'd1);
    xact(64'h8000_0010, 0, 0, 2'd3, 0, D0, 0, 3, 0);
    chk("ld_rflag", 64'(saw_rflag), 64'd1);
    xact(64'h8000_0012, 0, 0, 2'd1, 0, 64'h5566, 0, 3, 0);
    xact(64'h8000_0014, 0, 0, 2'd2, 0,
         64'h1122_3344, 0, 3, 0);

    xact(64'h8000_0005, 1, 64'h80, 2'd0, 0, 64'd0, 0, 3, 0);
    chk("sb_wmask", obs_wmask, 64'h0000_FF00_0000_0000);
    chk("sb_wdata", obs_wdata, 64'h0000_8000_0000_0000);
    xact(64'h8000_0005, 0, 0, 2'd0, 0,
         64'hFFFF_FFFF_FFFF_FF80, 0, 3, 0);
    xact(64'h8000_0005, 0, 0, 2'd0, 1, 64'h80, 0, 3, 0);
    xact(64'h8000_0004, 0, 0, 2'd1, 0,
         64'hFFFF_FFFF_FFFF_8000, 0, 3, 0);

    xact(64'h8000_0002, 0, 0, 2'd2, 0, 64'd0, 1, 1, 0);
    chk("mis_noacc", 64'(saw_wen | saw_rflag), 64'd0);
    xact(64'h7FFF_FFF8, 1, 64'h55, 2'd3, 0, 64'd0, 1, 1, 0);
    chk("oow_st_noacc", 64'(saw_wen | saw_rflag), 64'd0);
    xact(64'h87FF_FFFC, 0, 0, 2'd3, 0, 64'd0, 1, 1, 0);
    chk("oow_ld_noacc", 64'(saw_wen | saw_rflag), 64'd0);
    xact(64'h87FF_FFFC, 0, 0, 2'd2, 0, 64'd0, 0, 3, 0);
    chk("edge_rflag", 64'(saw_rflag), 64'd1);
    xact(64'h8800_0000, 0, 0, 2'd0, 0, 64'd0, 1, 1, 0);

    xact(64'h8000_0010, 0, 0, 2'd3, 0, D0, 0, 3, 5);
    xact(64'h8000_0002, 0, 0, 2'd2, 0, 64'd0, 1, 1, 5);

    xact(64'h8000_0020, 1, OLD, 2'd3, 0, 64'd0, 0, 3, 0);
    bus.req_valid    = 1'b1;
    bus.req_addr     = 64'h8000_0020;
    bus.req_wen      = 1'b1;
    bus.req_wdata    = 64'hDEAD;
    bus.req_size     = 2'd3;
    bus.req_unsigned = 1'b0;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_issue_wen", 64'(ram_wen), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_issue_idle", 64'(bus.req_ready), 64'd1);
    chk("rst_issue_nresp", 64'(bus.resp_valid), 64'd0);
    xact(64'h8000_0020, 0, 0, 2'd3, 0, OLD, 0, 3, 0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_ram_adapter.md
Name: lsu_ram_adapter

Overview:
Upstream neighbour of the DPI-backed RAM controller (RAMCtrl). Accepts one load/store request at a time from the LSU over a valid/ready handshake and converts it into RAMCtrl's 8-byte-aligned port signals: aligned address, byte-lane write mask, lane-shifted write data, and a read-start flag. Captures RAMCtrl's registered read data one cycle after issue, then extracts and sign- or zero-extends it. Returns the result over a valid/ready response channel with an error flag.

Parameters:
MEM_BASE, 64'h8000_0000, lowest legal byte address
MEM_SIZE, 64'h0800_0000, legal window size in bytes; legal addresses are MEM_BASE .. MEM_BASE+MEM_SIZE-1

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  adapter can accept
req_addr  in  64  byte address
req_wen  in  1  1 = store, 0 = load
req_wdata  in  64  store data, LSB-justified
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts
resp_rdata  out  64  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or out-of-window access
ram_raddr  out  64  to RAMCtrl raddr
ram_rflag  out  1  to RAMCtrl rflag, read-start marker
ram_rdata  in  64  from RAMCtrl rdata, valid the cycle after the issue edge
ram_waddr  out  64  to RAMCtrl waddr
ram_wdata  out  64  to RAMCtrl wdata
ram_wmask  out  64  to RAMCtrl wmask, bit mask (0xFF per enabled lane)
ram_wen  out  1  to RAMCtrl wen

Behaviour:
- States: IDLE, ISSUE, CAPTURE, RESP.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0.
- Reset values, continued: all request registers 0, so ram_raddr and ram_waddr are 0.
- While reset is high, ram_wen and ram_rflag are forced to 0 combinationally.
- req_ready = (state==IDLE) && !reset.
- Accept happens at a posedge with req_valid && req_ready. On accept, latch addr, wen, wdata, size and unsigned.
- Error check at accept:
  - misaligned when addr[2:0] mod (1<<size) != 0;
  - out-of-window when addr < MEM_BASE or addr+(1<<size)-1 > MEM_BASE+MEM_SIZE-1.
- On error: go directly to RESP with resp_err=1 and resp_rdata=0. No RAM access occurs: no wen, no rflag.
- Otherwise go to ISSUE.
- ISSUE, one cycle:
  - ram_raddr = ram_waddr = {addr[63:3],3'b0}.
  - Load: ram_rflag=1.
  - Store: ram_wen=1, ram_wdata = wdata << (8*addr[2:0]), ram_wmask = lane mask of (1<<size) bytes starting at lane addr[2:0].
  - Next state: CAPTURE.
- CAPTURE, one cycle: ram_rdata is valid.
  - Load: resp_rdata <= extend(ram_rdata >> (8*offset), size, unsigned).
  - Store: resp_rdata <= 0.
  - resp_err <= 0. Next state: RESP.
- Outside ISSUE: ram_wen=0, ram_rflag=0, ram_wmask=0. ram_raddr and ram_waddr hold the latched aligned address (RAMCtrl calls every cycle, so this must be a stable legal address).
- RESP: resp_valid=1. resp_rdata and resp_err stay stable until a posedge with resp_ready, then go to IDLE.
- Latency: accept at edge N gives resp_valid from cycle N+3 (N+1 for errors). Throughput is at most one request per 4 cycles; no accept while in RESP.
- Extension: size 3 passes all 64 bits and ignores unsigned. Otherwise take the low 8*(1<<size) bits, then sign- or zero-extend to 64 bits.
- Reset asserted in any state returns to IDLE at that edge. An in-flight store in ISSUE with reset high is suppressed (ram_wen gated). The response is dropped.

Decomposition:
- Package lsu_ram_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - state enum;
  - function lane_mask(size, offset) returning the 64-bit bit mask;
  - function extend(data, size, unsigned).
- One combinational sub-module, lsu_lane_align, computes the store shift and mask and the load shift and extension. The FSM stays in the top module.

Test Plan:
- Store then load, double: store addr 0x8000_0010, size 3, data 0x1122334455667788, then load the same address. Expect:
  - ISSUE drives wmask 0xFFFF_FFFF_FFFF_FFFF;
  - load resp_rdata 0x1122334455667788;
  - resp_valid 3 cycles after accept.
- Signed byte load: store byte 0x80 to 0x8000_0005, then load size 0 at the same address. Expect:
  - store wmask 0x0000_FF00_0000_0000 and wdata 0x0000_8000_0000_0000;
  - load with unsigned=0 gives 0xFFFF_FFFF_FFFF_FF80;
  - load with unsigned=1 gives 0x80.
- Misaligned word load at 0x8000_0002: expect resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, and ram_rflag/ram_wen never high.
- Out-of-window access: store to 0x7FFF_FFF8, then load to MEM_BASE+MEM_SIZE-4 with size 3. Expect resp_err=1 for both and no RAM access.
- Response backpressure: hold resp_ready=0 for 5 cycles after resp_valid rises. Expect resp_rdata and resp_err stable and req_ready=0 throughout; IDLE the cycle after the handshake.
- Reset during ISSUE of a store of 0xDEAD to 0x8000_0020: expect ram_wen=0 that cycle, IDLE next, and a subsequent load of 0x8000_0020 returning the old value.
